// File: rtl/teclado_matriz.sv
// Matrix keypad scanner: one-cold column drive, per-frame classification of
// closed keys, and a frame-rate debounce FSM that accepts one key at a time.
module teclado_matriz #(
  parameter int N_FILAS    = 4,
  parameter int N_COLS     = 4,
  parameter int DWELL      = 4,
  parameter int DEB_FRAMES = 3,
  localparam int CODE_W    = ($clog2(N_FILAS * N_COLS) < 1) ? 1 : $clog2(N_FILAS * N_COLS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_FILAS-1:0]  filas,
  output logic [N_COLS-1:0]   columnas,
  output logic [CODE_W-1:0]   tecla,
  output logic                tecla_valida,
  output logic                tecla_activa,
  output logic                multi_err
);

  localparam int COL_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int DW_W  = ($clog2(DWELL) < 1) ? 1 : $clog2(DWELL);
  localparam int CNT_W = ($clog2(DEB_FRAMES + 1) < 1) ? 1 : $clog2(DEB_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, PRESS_DEB, HELD, REL_DEB} state_t;

  // Closed-key counts only need to distinguish 0, 1 and "2 or more".
  function automatic logic [1:0] sat_add2(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > 3'd2) ? 2'd2 : s[1:0];
  endfunction

  logic [COL_W-1:0]  col_p0;
  logic [DW_W-1:0]   dcnt_p0;
  logic [1:0]        acc_hits_p0;
  logic [CODE_W-1:0] acc_code_p0;

  logic              sample, last_col, frame_end;
  logic [1:0]        col_hits, frame_hits;
  logic [CODE_W-1:0] col_code, frame_code;
  logic              f_none, f_single, f_multi;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
  logic [CODE_W-1:0] cand, cand_n;
  logic              deb_done, accept;

  assign sample    = (dcnt_p0 == DW_W'(DWELL - 1));
  assign last_col  = (col_p0 == COL_W'(N_COLS - 1));
  assign frame_end = sample && last_col;
  assign columnas  = ~(N_COLS'(1) << col_p0);

  // Stage p0: scan position and classification of the column being sampled
  always_comb begin
    col_hits = 2'd0;
    col_code = '0;
    for (int r = 0; r < N_FILAS; r++) begin
      if (!filas[r]) begin
        col_hits = sat_add2(col_hits, 2'd1);
        col_code = CODE_W'(int'(col_p0) * N_FILAS + r);
      end
    end
  end

  assign frame_hits = sat_add2(acc_hits_p0, col_hits);
  assign frame_code = (col_hits == 2'd1) ? col_code : acc_code_p0;
  assign f_none     = frame_end && (frame_hits == 2'd0);
  assign f_single   = frame_end && (frame_hits == 2'd1);
  assign f_multi    = frame_end && (frame_hits == 2'd2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_p0      <= '0;
      dcnt_p0     <= '0;
      acc_hits_p0 <= 2'd0;
      acc_code_p0 <= '0;
    end else if (sample) begin
      dcnt_p0 <= '0;
      if (last_col) begin
        col_p0      <= '0;
        acc_hits_p0 <= 2'd0;
        acc_code_p0 <= '0;
      end else begin
        col_p0      <= col_p0 + COL_W'(1);
        acc_hits_p0 <= frame_hits;
        acc_code_p0 <= frame_code;
      end
    end else begin
      dcnt_p0 <= dcnt_p0 + DW_W'(1);
    end
  end

  // Stage p1: debounce FSM, advanced only at frame end
  assign cnt_inc  = cnt + CNT_W'(1);
  assign deb_done = (cnt_inc == CNT_W'(DEB_FRAMES));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    accept  = 1'b0;
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (f_single) begin
            cand_n = frame_code;
            if (DEB_FRAMES == 1) begin
              accept  = 1'b1;
              state_n = HELD;
              cnt_n   = '0;
            end else begin
              state_n = PRESS_DEB;
              cnt_n   = CNT_W'(1);
            end
          end
        end
        PRESS_DEB: begin
          if (f_single) begin
            if (frame_code == cand) begin
              if (deb_done) begin
                accept  = 1'b1;
                state_n = HELD;
                cnt_n   = '0;
              end else begin
                cnt_n = cnt_inc;
              end
            end else begin
              cand_n = frame_code;
              cnt_n  = CNT_W'(1);
            end
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
        HELD: begin
          if (f_none) begin
            if (DEB_FRAMES == 1) begin
              state_n = IDLE;
              cnt_n   = '0;
            end else begin
              state_n = REL_DEB;
              cnt_n   = CNT_W'(1);
            end
          end
        end
        REL_DEB: begin
          if (f_none) begin
            if (deb_done) begin
              state_n = IDLE;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            state_n = HELD;
            cnt_n   = '0;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      cand         <= '0;
      tecla        <= '0;
      tecla_valida <= 1'b0;
      multi_err    <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      cand         <= cand_n;
      tecla_valida <= accept;
      multi_err    <= f_multi;
      if (accept) tecla <= frame_code;
    end
  end

  always_comb begin
    tecla_activa = (state == HELD) || (state == REL_DEB);
  end

endmodule

// File: doc/teclado_matriz.md
TECLADO_MATRIZ -- requirements
Module: teclado_matriz

Interface
REQ-001 SHALL have parameter N_FILAS, default 4, number of keypad rows (2..8).
REQ-002 SHALL have parameter N_COLS, default 4, number of keypad columns (2..8).
REQ-003 SHALL have parameter DWELL, default 4, clock cycles each column is held low (>=2).
REQ-004 SHALL have parameter DEB_FRAMES, default 3, consecutive identical scan frames required to accept a press or release (>=1).
REQ-005 SHALL have local parameter CODE_W = clog2(N_FILAS*N_COLS), minimum 1.
REQ-006 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-008 SHALL have port filas  input  N_FILAS  row lines, active-low (0 = key closed to driven column).
REQ-009 SHALL have port columnas  output  N_COLS  column drive, one-cold (exactly one bit 0).
REQ-010 SHALL have port tecla  output  CODE_W  code of last accepted key.
REQ-011 SHALL have port tecla_valida  output  1  one-cycle pulse on key acceptance.
REQ-012 SHALL have port tecla_activa  output  1  level, high while accepted key is held.
REQ-013 SHALL have port multi_err  output  1  one-cycle pulse after a frame with more than one key closed.

Function
REQ-014 SHALL drive column c low for DWELL consecutive cycles, then advance to c+1, wrapping N_COLS-1 -> 0; frame length = N_COLS*DWELL cycles.
REQ-015 SHALL sample filas only in the last dwell cycle (dwell count DWELL-1) of each column; earlier cycles are settling time and ignored.
REQ-016 SHALL classify each frame at the column N_COLS-1 sample: NONE (no low row bits in frame), SINGLE (exactly one), MULTI (two or more).
REQ-017 SHALL encode a SINGLE key at column c, row r as code = c*N_FILAS + r.
REQ-018 SHALL implement FSM states IDLE, PRESS_DEB, HELD, REL_DEB, evaluated once per frame end only.
REQ-019 IDLE: SINGLE -> PRESS_DEB, candidate = code, count = 1; NONE or MULTI -> stay IDLE.
REQ-020 PRESS_DEB: SINGLE same code -> count+1; different SINGLE -> restart, candidate = new code, count = 1; NONE or MULTI -> IDLE.
REQ-021 On count reaching DEB_FRAMES in PRESS_DEB (immediately when DEB_FRAMES = 1) SHALL enter HELD, load tecla = candidate, set tecla_activa = 1, pulse tecla_valida.
REQ-022 HELD: NONE -> REL_DEB, count = 1; any SINGLE or MULTI -> stay HELD; no second key accepted before release (no rollover).
REQ-023 REL_DEB: NONE -> count+1, at DEB_FRAMES -> IDLE, tecla_activa = 0; any non-NONE -> HELD.
REQ-024 tecla SHALL hold its value until the next acceptance, including through release.
REQ-025 tecla_valida and multi_err SHALL be registered and assert in the cycle after the frame-end sample, high exactly one cycle.
REQ-026 multi_err SHALL pulse for every MULTI frame regardless of FSM state.
REQ-027 Press latency SHALL be one cycle after the frame-end sample of the DEB_FRAMES-th consecutive matching frame.

Reset
REQ-028 While rst_n = 0 at a rising edge: columnas = all ones except bit 0 = 0, dwell count = 0, FSM = IDLE, counters = 0, tecla = 0, tecla_valida = 0, tecla_activa = 0, multi_err = 0.
REQ-029 Reset asserted mid-debounce or mid-hold SHALL discard candidate and frame accumulation; scanning restarts at column 0 in the first cycle after rst_n returns high.

Verification
REQ-030 Defaults, bench matrix model closes row 1/col 2 from cycle 0 after reset -> tecla = 9, tecla_valida one pulse at cycle 48 (end of frame 3 + 1), tecla_activa = 1 thereafter.
REQ-031 Key bounces (open during frame 2, closed otherwise) -> no tecla_valida until 3 consecutive clean frames after the bounce.
REQ-032 Release of held key 9 -> tecla_activa falls one cycle after 3rd consecutive NONE frame; tecla stays 9; no tecla_valida.
REQ-033 Keys row0/col0 and row3/col3 closed simultaneously -> multi_err pulses once per frame, no tecla_valida, FSM stays IDLE.
REQ-034 rst_n low for one cycle after 2 matching frames -> all outputs at reset values; acceptance needs 3 fresh frames.
REQ-035 Instance N_FILAS = 3, N_COLS = 5, DWELL = 2, DEB_FRAMES = 1: key row2/col4 -> tecla = 14 after one 10-cycle frame, columnas cycles through 5 one-cold values.
